masked_rr_arb: RTL and testbench

MASKED_RR_ARB -- requirements
Module: masked_rr_arb

---
 rtl/masked_rr_arb_pkg.sv | 19 +
 rtl/masked_rr_arb_rr_pick.sv | 43 ++++
 rtl/masked_rr_arb.sv | 149 ++++++++++++++
 tb/tb_masked_rr_arb.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// masked_rr_arb_pkg
// Shared definitions for the masked round-robin arbiter slice.
//   MAX_LANES : largest number of lanes the arbiter can be built with; the
//               per-lane logic is always generated over this many lanes
//   LANE_W    : width of a lane index (out_lane, round-robin pointer)
//   state_t   : output-register state, IDLE (empty) or HOLD (beat held)
// ---------------------------------------------------------------------------
package masked_rr_arb_pkg;

   localparam int MAX_LANES = 4;
   localparam int LANE_W    = $clog2(MAX_LANES);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/masked_rr_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority selector. Starting one lane above ptr and
// wrapping around, the first lane with req set wins.
// Ports:
//   req       in  MAX_LANES  eligible-and-valid request vector
//   ptr       in  LANE_W     lane granted most recently
//   grant     out MAX_LANES  one-hot grant (all zero when nothing requests)
//   grant_idx out LANE_W     index of the granted lane
//   any_grant out 1          some lane was granted
// ---------------------------------------------------------------------------
module rr_pick
   import masked_rr_arb_pkg::*;
(
   input  logic [MAX_LANES-1:0] req,
   input  logic [LANE_W-1:0]    ptr,
   output logic [MAX_LANES-1:0] grant,
   output logic [LANE_W-1:0]    grant_idx,
   output logic                 any_grant
);

   logic [LANE_W-1:0] idx;

   // Walk the lanes in priority order ptr+1, ptr+2, ... ptr. Lanes at or above
   // the populated size never request, so wrapping over MAX_LANES visits the
   // populated lanes in the same order as wrapping over the populated size.
   // The last step (k == MAX_LANES) revisits ptr itself as lowest priority.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = '0;
      for (int k = 1; k <= MAX_LANES; k++) begin
         idx = ptr + LANE_W'(k);
         if (!any_grant && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            any_grant  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/masked_rr_arb.sv
// ---------------------------------------------------------------------------
// masked_rr_arb
// Round-robin arbiter over SIZE lanes with a static lane-enable MASK and a
// one-beat registered output.
// Parameters: SIZE (1..MAX_LANES), MASK (lane enables), DW (payload width)
// Ports:
//   clk        in  1        clock, all state changes on posedge
//   rst        in  1        synchronous active-high reset
//   in_valid   in  SIZE     per-lane request
//   in_ready   out SIZE     per-lane accept, at most one bit high
//   in_data    in  SIZE*DW  per-lane payload, lane i at [i*DW +: DW]
//   out_valid  out 1        output register holds a beat
//   out_ready  in  1        downstream takes the beat
//   out_data   out DW       registered payload
//   out_lane   out LANE_W   source lane of out_data
//   grant_cnt  out SIZE*16  saturating per-lane grant counters, only present
//                           when MASKED_RR_ARB_STATS_EN is defined
// ---------------------------------------------------------------------------
module masked_rr_arb
   import masked_rr_arb_pkg::*;
#(
   parameter int                   SIZE = 4,
   parameter logic [MAX_LANES-1:0] MASK = 4'b1111,
   parameter int                   DW   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [SIZE-1:0]      in_valid,
   output logic [SIZE-1:0]      in_ready,
   input  logic [SIZE*DW-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic [LANE_W-1:0]    out_lane
`ifdef MASKED_RR_ARB_STATS_EN
   ,
   output logic [SIZE*16-1:0]   grant_cnt
`endif
);

   state_t                state_q, state_d;
   logic [DW-1:0]         data_q, data_d;
   logic [LANE_W-1:0]     lane_q, lane_d;
   logic [LANE_W-1:0]     ptr_q, ptr_d;

   logic [MAX_LANES-1:0]  req;
   logic [MAX_LANES-1:0]  grant;
   logic [LANE_W-1:0]     grant_idx;
   logic                  any_grant;
   logic                  load;
   logic [DW-1:0]         sel_data;

   // Lanes above SIZE are never elaborated against MASK or in_valid, so the
   // per-lane logic is safe for any SIZE up to MAX_LANES.
   for (genvar g = 0; g < MAX_LANES; g++) begin : g_lane
      if (g < SIZE) begin : g_pop
         assign req[g] = MASK[g] & in_valid[g];
      end else begin : g_unpop
         assign req[g] = 1'b0;
      end
   end

   rr_pick u_rr_pick (
      .req       (req),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // The output register can take a new beat when it is empty or when its
   // current beat is being consumed this cycle.
   assign load = (state_q == IDLE) || ((state_q == HOLD) && out_ready);

   // Next-state logic: on a load with a winner, capture its payload and
   // index and move the pointer to it; on a load with no winner the register
   // empties and the pointer stays. in_ready is suppressed during reset so a
   // held or offered beat is never acknowledged then.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      lane_d   = lane_q;
      ptr_d    = ptr_q;
      in_ready = '0;
      sel_data = '0;
      for (int i = 0; i < SIZE; i++) begin
         if (grant[i]) begin
            sel_data = in_data[i*DW +: DW];
         end
      end
      if (load && !rst) begin
         in_ready = grant[SIZE-1:0];
         if (any_grant) begin
            state_d = HOLD;
            data_d  = sel_data;
            lane_d  = grant_idx;
            ptr_d   = grant_idx;
         end else begin
            state_d = IDLE;
         end
      end
   end

   // ptr resets to the last populated lane so the first search starts at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         lane_q  <= '0;
         ptr_q   <= LANE_W'(SIZE - 1);
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         lane_q  <= lane_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid = (state_q == HOLD);
   assign out_data  = data_q;
   assign out_lane  = lane_q;

`ifdef MASKED_RR_ARB_STATS_EN
   logic [SIZE*16-1:0] cnt_q, cnt_d;

   // Each lane's counter bumps on its own grant and sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (load && any_grant) begin
         for (int i = 0; i < SIZE; i++) begin
            if (grant[i] && (cnt_q[i*16 +: 16] != 16'hFFFF)) begin
               cnt_d[i*16 +: 16] = cnt_q[i*16 +: 16] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_masked_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_masked_rr_arb
// Self-checking bench for masked_rr_arb. Four instances cover the default
// 4-lane build, a 3-lane build with lane 1 masked, a 2-lane build and an
// all-masked build. Inputs change on the falling edge, outputs are sampled
// on the falling edge (combinational in_ready a delta later).
// ---------------------------------------------------------------------------
module tb_masked_rr_arb;

   logic clk;
   logic rst;

   int tests_run;
   int tests_failed;

   // Expected beats, pushed when stimulus is applied, popped on delivery.
   logic [1:0] exp_lane_q[$];
   logic [7:0] exp_data_q[$];
   logic [1:0] exp_lane;
   logic [7:0] exp_data;

   // Instance A: SIZE=4, MASK=4'b1111
   logic [3:0]  a_in_valid;
   logic [3:0]  a_in_ready;
   logic [31:0] a_in_data;
   logic        a_out_valid;
   logic        a_out_ready;
   logic [7:0]  a_out_data;
   logic [1:0]  a_out_lane;

   // Instance B: SIZE=3, MASK=3'b101
   logic [2:0]  b_in_valid;
   logic [2:0]  b_in_ready;
   logic [23:0] b_in_data;
   logic        b_out_valid;
   logic        b_out_ready;
   logic [7:0]  b_out_data;
   logic [1:0]  b_out_lane;

   // Instance C: SIZE=2, MASK=2'b11
   logic [1:0]  c_in_valid;
   logic [1:0]  c_in_ready;
   logic [15:0] c_in_data;
   logic        c_out_valid;
   logic        c_out_ready;
   logic [7:0]  c_out_data;
   logic [1:0]  c_out_lane;

   // Instance D: SIZE=4, MASK=0
   logic [3:0]  d_in_valid;
   logic [3:0]  d_in_ready;
   logic [31:0] d_in_data;
   logic        d_out_valid;
   logic        d_out_ready;
   logic [7:0]  d_out_data;
   logic [1:0]  d_out_lane;

`ifdef MASKED_RR_ARB_STATS_EN
   logic [63:0] a_grant_cnt;
   logic [47:0] b_grant_cnt;
   logic [31:0] c_grant_cnt;
   logic [63:0] d_grant_cnt;
`endif

   masked_rr_arb #(.SIZE(4), .MASK(4'b1111), .DW(8)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data),
      .out_lane  (a_out_lane)
`ifdef MASKED_RR_ARB_STATS_EN
      ,
      .grant_cnt (a_grant_cnt)
`endif
   );

   masked_rr_arb #(.SIZE(3), .MASK(4'b0101), .DW(8)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .out_lane  (b_out_lane)
`ifdef MASKED_RR_ARB_STATS_EN
      ,
      .grant_cnt (b_grant_cnt)
`endif
   );

   masked_rr_arb #(.SIZE(2), .MASK(4'b0011), .DW(8)) dut_c (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (c_in_valid),
      .in_ready  (c_in_ready),
      .in_data   (c_in_data),
      .out_valid (c_out_valid),
      .out_ready (c_out_ready),
      .out_data  (c_out_data),
      .out_lane  (c_out_lane)
`ifdef MASKED_RR_ARB_STATS_EN
      ,
      .grant_cnt (c_grant_cnt)
`endif
   );

   masked_rr_arb #(.SIZE(4), .MASK(4'b0000), .DW(8)) dut_d (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (d_in_valid),
      .in_ready  (d_in_ready),
      .in_data   (d_in_data),
      .out_valid (d_out_valid),
      .out_ready (d_out_ready),
      .out_data  (d_out_data),
      .out_lane  (d_out_lane)
`ifdef MASKED_RR_ARB_STATS_EN
      ,
      .grant_cnt (d_grant_cnt)
`endif
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something stalls the sequence.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "[TB] watchdog");
   end

   // Reset values while rst is held with every lane requesting.
   task automatic test_reset();
      rst         = 1'b1;
      a_in_valid  = 4'hF;
      a_out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if (a_out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_out_valid: got %b expected 0", a_out_valid);
      end
      tests_run++;
      if (a_out_data !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL reset_out_data: got %h expected 00", a_out_data);
      end
      tests_run++;
      if (a_out_lane !== 2'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_out_lane: got %0d expected 0", a_out_lane);
      end
      tests_run++;
      if (a_in_ready !== 4'b0000) begin
         tests_failed++;
         $display("[TB] FAIL reset_in_ready: got %b expected 0000", a_in_ready);
      end
      @(negedge clk);
      rst        = 1'b0;
      a_in_valid = 4'h0;
      @(negedge clk);
      tests_run++;
      if (a_out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL idle_no_req: got out_valid %b expected 0", a_out_valid);
      end
   endtask

   // All four lanes requesting with out_ready high: one beat per cycle in
   // strict rotation starting from lane 0.
   task automatic test_rotation();
      a_in_valid  = 4'hF;
      a_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_lane_q.push_back(2'(i % 4));
         exp_data_q.push_back(8'hA0 + 8'(i % 4));
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tests_run++;
         if (a_out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rotation_valid[%0d]: got %b expected 1", i, a_out_valid);
         end else if (exp_lane_q.size() > 0) begin
            exp_lane = exp_lane_q.pop_front();
            exp_data = exp_data_q.pop_front();
            tests_run++;
            if (a_out_lane !== exp_lane || a_out_data !== exp_data) begin
               tests_failed++;
               $display("[TB] FAIL rotation_beat[%0d]: got lane %0d data %h expected lane %0d data %h",
                        i, a_out_lane, a_out_data, exp_lane, exp_data);
            end
         end
      end
      a_in_valid = 4'h0;
      @(negedge clk);
      tests_run++;
      if (a_out_valid !== 1'b0 || exp_lane_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL rotation_drain: got out_valid %b pending %0d expected 0 and 0",
                  a_out_valid, exp_lane_q.size());
      end
      exp_lane_q.delete();
      exp_data_q.delete();
   endtask

   // Lane 2 wins, downstream stalls for five cycles, then lane 3 is next.
   task automatic test_hold();
      a_in_valid  = 4'b0100;
      a_out_ready = 1'b0;
      #1;
      tests_run++;
      if (a_in_ready !== 4'b0100) begin
         tests_failed++;
         $display("[TB] FAIL hold_first_ready: got %b expected 0100", a_in_ready);
      end
      @(negedge clk);
      a_in_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
         #1;
         tests_run++;
         if (a_out_valid !== 1'b1 || a_out_lane !== 2'd2 || a_out_data !== 8'hA2 || a_in_ready !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL hold_stable[%0d]: got valid %b lane %0d data %h ready %b expected 1 2 a2 0000",
                     i, a_out_valid, a_out_lane, a_out_data, a_in_ready);
         end
         @(negedge clk);
      end
      a_out_ready = 1'b1;
      #1;
      tests_run++;
      if (a_in_ready !== 4'b1000) begin
         tests_failed++;
         $display("[TB] FAIL hold_next_ready: got %b expected 1000", a_in_ready);
      end
      @(negedge clk);
      tests_run++;
      if (a_out_valid !== 1'b1 || a_out_lane !== 2'd3 || a_out_data !== 8'hA3) begin
         tests_failed++;
         $display("[TB] FAIL hold_next_beat: got valid %b lane %0d data %h expected 1 3 a3",
                  a_out_valid, a_out_lane, a_out_data);
      end
      a_in_valid = 4'h0;
      @(negedge clk);
   endtask

   // Reset while holding a beat discards it; the first beat afterwards comes
   // from the lowest requesting lane.
   task automatic test_reset_in_hold();
      a_in_valid  = 4'b1000;
      a_out_ready = 1'b0;
      @(negedge clk);
      rst        = 1'b1;
      a_in_valid = 4'b0110;
      #1;
      tests_run++;
      if (a_in_ready !== 4'b0000) begin
         tests_failed++;
         $display("[TB] FAIL rst_hold_ready: got %b expected 0000", a_in_ready);
      end
      @(negedge clk);
      tests_run++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 4'b0000) begin
         tests_failed++;
         $display("[TB] FAIL rst_hold_cleared: got valid %b ready %b expected 0 0000", a_out_valid, a_in_ready);
      end
      rst         = 1'b0;
      a_out_ready = 1'b1;
      exp_lane_q.push_back(2'd1);
      exp_data_q.push_back(8'hA1);
      #1;
      tests_run++;
      if (a_in_ready !== 4'b0010) begin
         tests_failed++;
         $display("[TB] FAIL rst_first_ready: got %b expected 0010", a_in_ready);
      end
      @(negedge clk);
      a_in_valid = 4'h0;
      tests_run++;
      if (a_out_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL rst_first_valid: got %b expected 1", a_out_valid);
      end else begin
         exp_lane = exp_lane_q.pop_front();
         exp_data = exp_data_q.pop_front();
         tests_run++;
         if (a_out_lane !== exp_lane || a_out_data !== exp_data) begin
            tests_failed++;
            $display("[TB] FAIL rst_first_beat: got lane %0d data %h expected lane %0d data %h",
                     a_out_lane, a_out_data, exp_lane, exp_data);
         end
      end
      exp_lane_q.delete();
      exp_data_q.delete();
      @(negedge clk);
   endtask

   // Three lanes with lane 1 masked: grants alternate 0 and 2.
   task automatic test_mask();
      b_in_valid  = 3'b111;
      b_out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_lane_q.push_back((i % 2 == 0) ? 2'd0 : 2'd2);
         exp_data_q.push_back((i % 2 == 0) ? 8'hB0 : 8'hB2);
      end
      for (int i = 0; i < 6; i++) begin
         #1;
         tests_run++;
         if (b_in_ready[1] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mask_ready1[%0d]: got %b expected 0", i, b_in_ready[1]);
         end
         @(negedge clk);
         tests_run++;
         if (b_out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mask_valid[%0d]: got %b expected 1", i, b_out_valid);
         end else begin
            exp_lane = exp_lane_q.pop_front();
            exp_data = exp_data_q.pop_front();
            tests_run++;
            if (b_out_lane !== exp_lane || b_out_data !== exp_data) begin
               tests_failed++;
               $display("[TB] FAIL mask_beat[%0d]: got lane %0d data %h expected lane %0d data %h",
                        i, b_out_lane, b_out_data, exp_lane, exp_data);
            end
         end
      end
      exp_lane_q.delete();
      exp_data_q.delete();
      b_in_valid = 3'b000;
      @(negedge clk);
   endtask

   // Two populated lanes in a four-lane build: grants alternate 0 and 1.
   task automatic test_size2();
      c_in_valid  = 2'b11;
      c_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_lane_q.push_back(2'(i % 2));
         exp_data_q.push_back(8'hC0 + 8'(i % 2));
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests_run++;
         if (c_out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL size2_valid[%0d]: got %b expected 1", i, c_out_valid);
         end else begin
            exp_lane = exp_lane_q.pop_front();
            exp_data = exp_data_q.pop_front();
            tests_run++;
            if (c_out_lane !== exp_lane || c_out_data !== exp_data) begin
               tests_failed++;
               $display("[TB] FAIL size2_beat[%0d]: got lane %0d data %h expected lane %0d data %h",
                        i, c_out_lane, c_out_data, exp_lane, exp_data);
            end
         end
      end
      exp_lane_q.delete();
      exp_data_q.delete();
      c_in_valid = 2'b00;
      @(negedge clk);
   endtask

   // Every lane masked: no acceptance and no output, whatever is requested.
   task automatic test_mask_zero();
      d_in_valid  = 4'hF;
      d_out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         tests_run++;
         if (d_out_valid !== 1'b0 || d_in_ready !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL mask_zero[%0d]: got valid %b ready %b expected 0 0000", i, d_out_valid, d_in_ready);
         end
         @(negedge clk);
      end
      d_in_valid = 4'h0;
   endtask

`ifdef MASKED_RR_ARB_STATS_EN
   // Lane 0 alone for more than 65535 beats: its counter saturates and the
   // others stay at zero.
   task automatic test_stats();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (a_grant_cnt !== 64'd0) begin
         tests_failed++;
         $display("[TB] FAIL stats_reset: got %h expected 0", a_grant_cnt);
      end
      a_in_valid  = 4'b0001;
      a_out_ready = 1'b1;
      repeat (70000) @(negedge clk);
      tests_run++;
      if (a_grant_cnt[15:0] !== 16'hFFFF) begin
         tests_failed++;
         $display("[TB] FAIL stats_lane0: got %h expected ffff", a_grant_cnt[15:0]);
      end
      tests_run++;
      if (a_grant_cnt[63:16] !== 48'd0) begin
         tests_failed++;
         $display("[TB] FAIL stats_others: got %h expected 0", a_grant_cnt[63:16]);
      end
      a_in_valid = 4'h0;
      @(negedge clk);
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      a_in_valid   = '0;
      a_out_ready  = 1'b0;
      a_in_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      b_in_valid   = '0;
      b_out_ready  = 1'b0;
      b_in_data    = {8'hB2, 8'hB1, 8'hB0};
      c_in_valid   = '0;
      c_out_ready  = 1'b0;
      c_in_data    = {8'hC1, 8'hC0};
      d_in_valid   = '0;
      d_out_ready  = 1'b0;
      d_in_data    = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
      @(negedge clk);

      test_reset();
      test_rotation();
      test_hold();
      test_reset_in_hold();
      test_mask();
      test_size2();
      test_mask_zero();
`ifdef MASKED_RR_ARB_STATS_EN
      test_stats();
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
